// File: rtl/ifetch_queue_if.sv
// Fetch-stage bus bundle: redirect/stall control from ID, the instruction
// memory request/response pair, and the head-of-queue view into IF/ID.
interface ifetch_queue_if;
  // control from the ID-stage hazard/branch unit
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  // instruction memory read port
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  // head of the prefetch queue toward IF/ID
  logic        if_valid;
  logic [31:0] if_pc_plus_4;
  logic [31:0] if_instruction;

  // master: the fetch unit itself
  modport master (
    input  redirect_valid, redirect_pc, id_stall, im_rvalid, im_rdata,
    output im_req, im_addr, if_valid, if_pc_plus_4, if_instruction
  );

  // slave: the surrounding pipeline and memory
  modport slave (
    output redirect_valid, redirect_pc, id_stall, im_rvalid, im_rdata,
    input  im_req, im_addr, if_valid, if_pc_plus_4, if_instruction
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: owns the fetch PC, keeps one read in flight to
// instruction memory, and buffers returned words in a 2-entry queue that
// drains into IF/ID. A redirect empties the queue and squashes the read.
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  ifetch_queue_if.master bus
);

  typedef struct packed {
    logic [31:0] pc_plus_4;
    logic [31:0] instr;
  } entry_t;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_addr_q, req_addr_d;   // address of the read in flight
  entry_t      head_q, head_d;
  entry_t      tail_q, tail_d;
  logic [1:0]  count_q, count_d;
  logic        outstanding_q, outstanding_d;
  logic        squash_q, squash_d;

  logic        pop, live, push, issue, resp_hit;
  logic [2:0]  occ;
  entry_t      resp;

  assign pop      = (count_q != 2'd0) & ~bus.id_stall;
  assign live     = outstanding_q & ~squash_q;
  assign resp_hit = bus.im_rvalid & outstanding_q;
  assign push     = resp_hit & ~squash_q;
  // Occupancy after this cycle if nothing new issues; a live read already
  // owns a slot, so the queue can never overflow.
  assign occ      = {1'b0, count_q} + {2'b00, live} - {2'b00, pop};
  assign issue    = ~rst & ~bus.redirect_valid & (~outstanding_q | bus.im_rvalid) &
                    (occ < 3'd2);

  assign resp.pc_plus_4 = req_addr_q + 32'd4;
  assign resp.instr     = bus.im_rdata;

  assign bus.im_req         = issue;
  assign bus.im_addr        = fetch_pc_q;
  assign bus.if_valid       = (count_q != 2'd0);
  assign bus.if_pc_plus_4   = bus.if_valid ? head_q.pc_plus_4 : 32'd0;
  assign bus.if_instruction = bus.if_valid ? head_q.instr     : 32'd0;

  // Next-state: redirect wins over issue, push and pop.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    req_addr_d    = req_addr_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    squash_d      = squash_q;
    if (bus.redirect_valid) begin
      fetch_pc_d    = bus.redirect_pc;
      count_d       = 2'd0;
      // A read still in flight must have its data dropped when it lands;
      // one landing right now is simply discarded.
      outstanding_d = outstanding_q & ~bus.im_rvalid;
      squash_d      = outstanding_q & ~bus.im_rvalid;
    end else begin
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + 32'd4;
        req_addr_d    = fetch_pc_q;
        outstanding_d = 1'b1;
        squash_d      = 1'b0;
      end else if (resp_hit) begin
        outstanding_d = 1'b0;
        squash_d      = 1'b0;
      end
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_d = resp;
          else                 tail_d = resp;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // count stays; head advances and the new word lands behind it
          if (count_q == 2'd1) begin
            head_d = resp;
          end else begin
            head_d = tail_q;
            tail_d = resp;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers; reset drops any read in flight and restarts at RESET_PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      req_addr_q    <= RESET_PC;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= 2'd0;
      outstanding_q <= 1'b0;
      squash_q      <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      req_addr_q    <= req_addr_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      squash_q      <= squash_d;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a latency-configurable memory model
// that returns word == address.
module tb_ifetch_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;

  ifetch_queue_if bus();

  ifetch_queue #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          lat      = 1;
  bit          pend     = 1'b0;
  int          pend_cd  = 0;
  logic [31:0] pend_addr = '0;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc4, s_ins;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at the negedge, sample outputs, model memory.
  task automatic cyc(input logic redir, input logic [31:0] rpc, input logic stall);
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.id_stall       = stall;
    if (pend && pend_cd <= 1) begin
      bus.im_rvalid = 1'b1;
      bus.im_rdata  = pend_addr;
      pend          = 1'b0;
    end else begin
      bus.im_rvalid = 1'b0;
      bus.im_rdata  = '0;
      if (pend) pend_cd--;
    end
    #1;
    s_req   = bus.im_req;
    s_addr  = bus.im_addr;
    s_valid = bus.if_valid;
    s_pc4   = bus.if_pc_plus_4;
    s_ins   = bus.if_instruction;
    if (s_req) begin
      pend      = 1'b1;
      pend_cd   = lat;
      pend_addr = s_addr;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    pend               = 1'b0;
    bus.im_rvalid      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.id_stall       = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_stall       = 1'b0;
    bus.im_rvalid      = 1'b0;
    bus.im_rdata       = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req",   32'(bus.im_req),   32'd0);
    chk("rst_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_pc4",   bus.if_pc_plus_4,  32'd0);
    chk("rst_ins",   bus.if_instruction, 32'd0);

    // streaming with 1-cycle memory
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 32'd0, 1'b0);
      chk("t1_req",  32'(s_req), 32'd1);
      chk("t1_addr", s_addr, 32'(4 * i));
      if (i >= 2) begin
        chk("t1_valid", 32'(s_valid), 32'd1);
        chk("t1_pc4",   s_pc4, 32'(4 * (i - 1)));
        chk("t1_ins",   s_ins, 32'(4 * (i - 2)));
      end else begin
        chk("t1_valid0", 32'(s_valid), 32'd0);
      end
    end

    // decode stall fills the queue, then drains back-to-back
    do_reset();
    lat = 1;
    cyc(1'b0, 32'd0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 32'd0, 1'b1);
      chk("t2_req0",  32'(s_req), 32'd0);
      chk("t2_valid", 32'(s_valid), 32'd1);
      chk("t2_pc4",   s_pc4, 32'd4);
      chk("t2_ins",   s_ins, 32'd0);
    end
    cyc(1'b0, 32'd0, 1'b0);
    chk("t2_rel_ins0", s_ins, 32'h0);
    chk("t2_rel_req",  32'(s_req), 32'd1);
    chk("t2_rel_addr", s_addr, 32'h8);
    cyc(1'b0, 32'd0, 1'b0);
    chk("t2_rel_ins4", s_ins, 32'h4);
    cyc(1'b0, 32'd0, 1'b0);
    chk("t2_rel_ins8", s_ins, 32'h8);

    // redirect while a 3-cycle read of 0x10 is in flight
    do_reset();
    lat = 3;
    for (int i = 0; i < 12; i++) cyc(1'b0, 32'd0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0);
    chk("t3_req10",  32'(s_req), 32'd1);
    chk("t3_addr10", s_addr, 32'h10);
    cyc(1'b1, 32'h100, 1'b0);
    chk("t3_redir_req",   32'(s_req), 32'd0);
    chk("t3_redir_valid", 32'(s_valid), 32'd1);
    chk("t3_redir_ins",   s_ins, 32'hC);
    cyc(1'b0, 32'd0, 1'b0);
    chk("t3_empty",  32'(s_valid), 32'd0);
    chk("t3_noreq",  32'(s_req), 32'd0);
    cyc(1'b0, 32'd0, 1'b0);
    chk("t3_req100",  32'(s_req), 32'd1);
    chk("t3_addr100", s_addr, 32'h100);
    chk("t3_drop",    32'(s_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'd0, 1'b0);
      chk("t3_wait_empty", 32'(s_valid), 32'd0);
    end
    cyc(1'b0, 32'd0, 1'b0);
    chk("t3_valid", 32'(s_valid), 32'd1);
    chk("t3_pc4",   s_pc4, 32'h104);
    chk("t3_ins",   s_ins, 32'h100);

    // redirect coinciding with a response and a pop
    do_reset();
    lat = 1;
    cyc(1'b0, 32'd0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0);
    cyc(1'b1, 32'h200, 1'b0);
    chk("t4_req0",  32'(s_req), 32'd0);
    chk("t4_head",  s_pc4, 32'h4);
    cyc(1'b0, 32'd0, 1'b0);
    chk("t4_empty", 32'(s_valid), 32'd0);
    chk("t4_req",   32'(s_req), 32'd1);
    chk("t4_addr",  s_addr, 32'h200);
    cyc(1'b0, 32'd0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0);
    chk("t4_pc4", s_pc4, 32'h204);
    chk("t4_ins", s_ins, 32'h200);

    // fetch PC wraparound
    do_reset();
    lat = 1;
    cyc(1'b1, 32'hFFFF_FFFC, 1'b0);
    chk("t5_req0", 32'(s_req), 32'd0);
    cyc(1'b0, 32'd0, 1'b0);
    chk("t5_addr_top", s_addr, 32'hFFFF_FFFC);
    cyc(1'b0, 32'd0, 1'b0);
    chk("t5_addr_wrap", s_addr, 32'h0);
    cyc(1'b0, 32'd0, 1'b0);
    chk("t5_valid", 32'(s_valid), 32'd1);
    chk("t5_pc4",   s_pc4, 32'h0);
    chk("t5_ins",   s_ins, 32'hFFFF_FFFC);

    // asynchronous reset mid-cycle with a read in flight
    do_reset();
    lat = 1;
    cyc(1'b0, 32'd0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0);
    bus.im_rvalid = 1'b0;
    #2;
    chk("t6_pre_valid", 32'(bus.if_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_req",   32'(bus.im_req),    32'd0);
    chk("t6_valid", 32'(bus.if_valid),  32'd0);
    chk("t6_pc4",   bus.if_pc_plus_4,   32'd0);
    chk("t6_ins",   bus.if_instruction, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 32'd0, 1'b0);   // stale response for 0x8 lands here
    chk("t6_restart_req",  32'(s_req), 32'd1);
    chk("t6_restart_addr", s_addr, 32'h0);
    cyc(1'b0, 32'd0, 1'b0);
    chk("t6_stale_ignored", 32'(s_valid), 32'd0);
    cyc(1'b0, 32'd0, 1'b0);
    chk("t6_valid", 32'(s_valid), 32'd1);
    chk("t6_pc4",   s_pc4, 32'h4);
    chk("t6_ins",   s_ins, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
